delay_bram_scheduler: RTL and testbench
=======================================

# delay_bram_scheduler

Time-multiplexes one dual-port BRAM among `CHANNELS` independent sample-delay lines, each with its own runtime length. On every sample tick it sequences a read-then-write per channel, then presents all delayed outputs at once. It sits between the voice/effect datapath (reverb combs, echo taps) and the shared BRAM, replacing one BRAM per delay line.

## Interface
- `WIDTH`, 32, sample width in bits
- `CHANNELS`, 4, number of delay lines; ≥1
- `CH_MAXLEN`, 2048, per-channel region depth; power of two
- `clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `sample_tick`  in  1  one-cycle pulse at sample rate
- `len`  in  CHANNELS×32  per-channel delay in samples, channel c at bits [32c+31:32c]
- `in`  in  CHANNELS×WIDTH  per-channel input samples, same packing
- `out`  out  CHANNELS×WIDTH  per-channel delayed samples, registered
- `out_valid`  out  1  one-cycle pulse when `out` updates
- `busy`  out  1  high while a tick is being processed
- `overrun`  out  1  sticky; set when a tick arrives while busy

## Operation
- Reset: `out`=0, `out_valid`=0, `busy`=0, `overrun`=0, all ring pointers=0, all fill counters=0, FSM=IDLE.
- IDLE: on `sample_tick`, snapshot `in` and `len` into registers, ch=0, go RD.
- RD: drive BRAM read address {ch, ptr[ch]}; go LAT.
- LAT: wait for registered BRAM read (1-cycle latency); go WR.
- WR: write snapshot `in[ch]` to {ch, ptr[ch]}, wr_en=1. Capture `data_out` into the staging register for ch, or 0 if fill[ch] < eff_len[ch]. Advance ptr[ch] = (ptr+1 == eff_len) ? 0 : ptr+1. Increment fill[ch], saturating at eff_len. If ch==CHANNELS-1 go DONE, else ch+1, go RD.
- DONE: copy staging into `out`, pulse `out_valid`, go IDLE.
- eff_len = clamp(len, 1, CH_MAXLEN); len=0 behaves as 1; len>CH_MAXLEN behaves as CH_MAXLEN.
- Delay semantics: the output on tick n equals the input from tick n−eff_len, or 0 before eff_len inputs have been written.
- Length change (snapshot differs from previous eff_len[ch]): if ptr[ch] ≥ new eff_len, set ptr[ch] to 0. Always clear fill[ch] on a change, so outputs are zero until the line refills. An unchanged length leaves state intact.
- `sample_tick` outside IDLE: dropped and sets `overrun`. In-flight processing is unaffected.
- Channels occupy disjoint address regions, so there is no cross-channel collision. Within a channel, the read (RD) precedes the write (WR), so read-during-write never occurs.

## Timing
- Tick sampled in cycle T. Channel c RD at T+1+3c, WR at T+3+3c. DONE at T+1+3·CHANNELS.
- `out`/`out_valid` visible in cycle T+2+3·CHANNELS, with `out_valid` high for exactly that one cycle. `out` holds its value until the next DONE.
- `busy` is high from T+1 through the DONE cycle inclusive.
- A tick may be accepted in the cycle after DONE (IDLE). Minimum tick spacing is 3·CHANNELS+2 cycles.
- `rst` asserted in any state: reset values apply the next cycle, the pending sequence is abandoned, and no `out_valid` is produced. BRAM contents are not cleared; fill counters mask them.

## Structure
- Package `fifo_delay_pkg`:
  - state enum {IDLE, RD, LAT, WR, DONE}
  - localparams CH_AW = $clog2(CH_MAXLEN), CHW = $clog2(CHANNELS) (min 1)
  - function `eff_len` (clamp)
- Sub-module: existing `BRAM_inst` (DATA_WIDTH=WIDTH, ADDR_WIDTH=CHW+CH_AW, registered read, clocked on `clk`). Address = {ch, ptr}.
- Per-channel ptr/fill/last_len registers are arrays. The FSM lives in this module.

## Test plan
- CHANNELS=4, all len=3, ch0 inputs 1,2,3,4,5 on successive ticks -> ch0 `out` 0,0,0,1,2. Other channels are independent with their own values.
- len=1 on ch1 with inputs 7,8 -> `out` 0,7. len=0 gives identical results.
- len=5000 on ch2 -> first nonzero output on tick 2049 equals tick-1 input (clamped to 2048).
- Second tick 4 cycles after the first -> `overrun`=1 and stays 1. Exactly one `out_valid`, at T+14, with correct data.
- ch3 len 8→4 after 6 ticks (ptr=6) -> ptr=0. Four zero outputs, then 4-tick delay resumes.
- `rst` pulsed mid-sequence (state WR, ch=1) -> next cycle `busy`=0, `out`=0, no `out_valid`. The following tick outputs 0 (fill cleared).

Source files
------------

// File: rtl/delay_bram_scheduler_pkg.sv
// fifo_delay_pkg: shared types and helpers for delay_bram_scheduler.
//   state_e     - scheduler FSM states
//   CH_AW/CHW   - address widths for the default configuration
//   clog2_min1  - ceil(log2(n)) but never below 1 (keeps vectors legal)
//   eff_len     - clamps a requested delay into [1, maxlen]
package fifo_delay_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int unsigned DEF_CHANNELS  = 4;
  localparam int unsigned DEF_CH_MAXLEN = 2048;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned CH_AW = clog2_min1(DEF_CH_MAXLEN);
  localparam int unsigned CHW   = clog2_min1(DEF_CHANNELS);

  function automatic logic [31:0] eff_len(input logic [31:0] l, input int unsigned maxlen);
    if (l == 32'd0)         return 32'd1;
    if (l > 32'(maxlen))    return 32'(maxlen);
    return l;
  endfunction

endpackage

// File: rtl/delay_bram_scheduler_bram.sv
// BRAM_inst: simple dual-port RAM, one write port and one read port,
// both on clk. Read data is registered (one cycle latency).
//   clk        - clock
//   we_i       - write enable
//   waddr_i    - write address
//   wdata_i    - write data
//   raddr_i    - read address
//   rdata_o    - registered read data
module BRAM_inst #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/delay_bram_scheduler.sv
// delay_bram_scheduler: CHANNELS sample-delay lines sharing one BRAM.
// Each sample tick runs a read-latency-write pass per channel, then
// presents all delayed samples together.
//   clk, rst     - clock, synchronous active-high reset
//   sample_tick  - one-cycle pulse at sample rate
//   len          - per-channel delay (32 bits per channel, ch0 in LSBs)
//   in           - per-channel input samples (WIDTH bits per channel)
//   out          - per-channel delayed samples, registered
//   out_valid    - one-cycle pulse when out updates
//   busy         - high while a tick is being processed
//   overrun      - sticky, set when a tick arrives while busy
module delay_bram_scheduler
  import fifo_delay_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CH_MAXLEN = 2048
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic [CHANNELS*32-1:0]    len,
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned PTR_W = clog2_min1(CH_MAXLEN);
  localparam int unsigned CH_W  = clog2_min1(CHANNELS);
  localparam int unsigned LEN_W = PTR_W + 1;
  localparam int unsigned AW    = CH_W + PTR_W;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

  state_e state_q, state_d;
  logic [CH_W-1:0]  ch_q;
  logic [PTR_W-1:0] ptr_q      [CHANNELS];
  logic [LEN_W-1:0] fill_q     [CHANNELS];
  logic [LEN_W-1:0] last_len_q [CHANNELS];
  logic [WIDTH-1:0] in_q       [CHANNELS];
  logic [WIDTH-1:0] stage_q    [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] out_q;
  logic out_valid_q, overrun_q;

  logic [LEN_W-1:0] eff_w [CHANNELS];
  logic [PTR_W-1:0] cur_ptr, ptr_adv;
  logic [LEN_W-1:0] cur_len, cur_fill, ptr_inc;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] rd_data, wr_data;
  logic             we;

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      eff_w[c] = LEN_W'(eff_len(len[32*c +: 32], CH_MAXLEN));
    end
  end

  always_comb begin
    cur_ptr  = ptr_q[ch_q];
    cur_len  = last_len_q[ch_q];
    cur_fill = fill_q[ch_q];
    ptr_inc  = {1'b0, cur_ptr} + LEN_W'(1);
    ptr_adv  = (ptr_inc == cur_len) ? '0 : ptr_inc[PTR_W-1:0];
    // Read and write share the address: read in RD, write in WR of the same slot.
    addr     = {ch_q, cur_ptr};
    we       = (state_q == WR);
    wr_data  = in_q[ch_q];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = RD;
      RD:      state_d = LAT;
      LAT:     state_d = WR;
      WR:      state_d = (ch_q == CH_LAST) ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        ptr_q[c]      <= '0;
        fill_q[c]     <= '0;
        last_len_q[c] <= '0;
        in_q[c]       <= '0;
        stage_q[c]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      if (sample_tick && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            ch_q <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              in_q[c]       <= in[WIDTH*c +: WIDTH];
              last_len_q[c] <= eff_w[c];
              // A length change restarts the fill; pointer only moves if it
              // would now fall outside the shortened ring.
              if (eff_w[c] != last_len_q[c]) begin
                fill_q[c] <= '0;
                if ({1'b0, ptr_q[c]} >= eff_w[c]) ptr_q[c] <= '0;
              end
            end
          end
        end
        WR: begin
          stage_q[ch_q] <= (cur_fill < cur_len) ? '0 : rd_data;
          ptr_q[ch_q]   <= ptr_adv;
          if (cur_fill < cur_len) fill_q[ch_q] <= cur_fill + LEN_W'(1);
          if (ch_q != CH_LAST) ch_q <= ch_q + 1'b1;
        end
        DONE: begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            out_q[WIDTH*c +: WIDTH] <= stage_q[c];
          end
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  BRAM_inst #(
    .DATA_WIDTH(WIDTH),
    .ADDR_WIDTH(AW)
  ) u_bram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (addr),
    .wdata_i (wr_data),
    .raddr_i (addr),
    .rdata_o (rd_data)
  );

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_delay_bram_scheduler.sv
`timescale 1ns/1ps
module tb_delay_bram_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick_r;
  logic [127:0] len_r;
  logic [127:0] in_r;
  logic [127:0] out_w;
  logic         out_valid_w, busy_w, overrun_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_count = 0;
  int last_valid_cyc = -1;
  logic [127:0] exp_q [$];
  logic [127:0] mon_exp;

  delay_bram_scheduler #(
    .WIDTH(32),
    .CHANNELS(4),
    .CH_MAXLEN(2048)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(tick_r),
    .len        (len_r),
    .in         (in_r),
    .out        (out_w),
    .out_valid  (out_valid_w),
    .busy       (busy_w),
    .overrun    (overrun_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] p4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Monitor: every out_valid pops one expected vector.
  always @(negedge clk) begin
    if (out_valid_w) begin
      valid_count++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        for (int c = 0; c < 4; c++)
          chk($sformatf("out_ch%0d", c), out_w[32*c +: 32], mon_exp[32*c +: 32]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_valid(input int start);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_count != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=0 expected=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic do_tick(input logic [127:0] l, input logic [127:0] d, input logic [127:0] e);
    int start;
    exp_q.push_back(e);
    len_r  = l;
    in_r   = d;
    tick_r = 1'b1;
    step();
    tick_r = 1'b0;
    in_r   = '1;  // the snapshot must be used, not the live input
    start  = valid_count;
    wait_valid(start);
  endtask

  initial begin
    int t0;
    int start;
    rst = 1'b1; tick_r = 1'b0; len_r = '0; in_r = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_out", out_w, '0);
    chk("reset_out_valid", {127'd0, out_valid_w}, '0);
    chk("reset_busy", {127'd0, busy_w}, '0);
    chk("reset_overrun", {127'd0, overrun_w}, '0);

    // All lines length 3.
    do_tick(p4(3,3,3,3), p4(1,10,20,30), p4(0,0,0,0));
    do_tick(p4(3,3,3,3), p4(2,11,21,31), p4(0,0,0,0));
    do_tick(p4(3,3,3,3), p4(3,12,22,32), p4(0,0,0,0));
    do_tick(p4(3,3,3,3), p4(4,13,23,33), p4(1,10,20,30));
    do_tick(p4(3,3,3,3), p4(5,14,24,34), p4(2,11,21,31));
    repeat (5) step();
    chk("out_hold", out_w, p4(2,11,21,31));

    // Length 0/1/2/over-max.
    do_reset();
    do_tick(p4(0,1,2,2048), p4(7,7,5,1), p4(0,0,0,0));
    do_tick(p4(0,1,2,2048), p4(8,8,6,2), p4(7,7,0,0));

    // Second tick 4 cycles after the first is dropped.
    chk("overrun_before", {127'd0, overrun_w}, '0);
    exp_q.push_back(p4(8,8,5,0));
    len_r = p4(0,1,2,2048); in_r = p4(9,9,9,9); tick_r = 1'b1;
    step();
    tick_r = 1'b0;
    t0 = cyc;
    start = valid_count;
    repeat (3) step();
    in_r = p4(99,99,99,99); tick_r = 1'b1;
    step();
    tick_r = 1'b0;
    chk("overrun_set", {127'd0, overrun_w}, 128'd1);
    chk("busy_during", {127'd0, busy_w}, 128'd1);
    wait_valid(start);
    chk("out_valid_latency", last_valid_cyc - t0, 128'd13);
    repeat (20) step();
    chk("single_out_valid", valid_count - start, 128'd1);
    chk("overrun_sticky", {127'd0, overrun_w}, 128'd1);
    chk("busy_idle", {127'd0, busy_w}, '0);
    do_tick(p4(0,1,2,2048), p4(10,10,10,10), p4(9,9,6,0));

    // ch3 length 8 -> 4 after six ticks.
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      do_tick(p4(2, 1, 3, (k <= 6) ? 8 : 4),
              p4(100+k, 200+k, 300+k, k),
              p4((k > 2) ? 100+k-2 : 0,
                 (k > 1) ? 200+k-1 : 0,
                 (k > 3) ? 300+k-3 : 0,
                 (k >= 11) ? k-4 : 0));
    end

    // Reset while ch1 is in WR.
    do_reset();
    do_tick(p4(1,1,1,1), p4(1,2,3,4), p4(0,0,0,0));
    do_tick(p4(1,1,1,1), p4(5,6,7,8), p4(1,2,3,4));
    len_r = p4(1,1,1,1); in_r = p4(9,10,11,12); tick_r = 1'b1;
    step();
    tick_r = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", {127'd0, busy_w}, '0);
    chk("midrst_out", out_w, '0);
    chk("midrst_out_valid", {127'd0, out_valid_w}, '0);
    start = valid_count;
    repeat (20) step();
    chk("midrst_no_valid", valid_count - start, '0);
    do_tick(p4(1,1,1,1), p4(13,14,15,16), p4(0,0,0,0));
    do_tick(p4(1,1,1,1), p4(17,18,19,20), p4(13,14,15,16));

    // Over-length request clamps to 2048 on ch2.
    do_reset();
    for (int k = 1; k <= 2050; k++) begin
      do_tick(p4(1, 1, 5000, 2048),
              p4(k, k+1000, k, k+50000),
              p4((k > 1) ? k-1 : 0,
                 (k > 1) ? k-1+1000 : 0,
                 (k >= 2049) ? k-2048 : 0,
                 (k >= 2049) ? k-2048+50000 : 0));
    end

    repeat (5) step();
    chk("scoreboard_drained", exp_q.size(), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
